// File: rtl/mc_controller.sv
// Multicycle controller: Moore main FSM, ALU decoder, condition check and
// flag register producing the datapath select lines and write strobes.
module mc_controller (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] cond_i,
  input  logic [1:0] op_i,
  input  logic [5:0] funct_i,
  input  logic [3:0] rd_i,
  input  logic [3:0] alu_flags_i,
  output logic       pc_write_o,
  output logic       ir_write_o,
  output logic       reg_write_o,
  output logic       mem_write_o,
  output logic       adr_src_o,
  output logic       alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic [1:0] result_src_o,
  output logic [1:0] reg_src_o,
  output logic [1:0] imm_src_o,
  output logic [1:0] alu_control_o
);

  typedef enum logic [3:0] {
    StFetch, StDecode, StMemAdr, StMemRd, StMemWb, StMemWr,
    StExecuteR, StExecuteI, StAluWb, StBranch, StUnknown
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;
  logic       cond_ex_r_q;

  logic       next_pc, ir_w, reg_w, mem_w, branch, alu_op;
  logic       cond_ex, pcs, is_add, is_sub;
  logic [1:0] flag_w;
  logic       n, z, c, v;

  always_comb begin
    state_d      = state_q;
    next_pc      = 1'b0;
    ir_w         = 1'b0;
    reg_w        = 1'b0;
    mem_w        = 1'b0;
    branch       = 1'b0;
    alu_op       = 1'b0;
    adr_src_o    = 1'b0;
    alu_src_a_o  = 1'b0;
    alu_src_b_o  = 2'b00;
    result_src_o = 2'b00;
    unique case (state_q)
      StFetch: begin
        ir_w         = 1'b1;
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        next_pc      = 1'b1;
        state_d      = StDecode;
      end
      StDecode: begin
        alu_src_a_o  = 1'b1;
        alu_src_b_o  = 2'b10;
        result_src_o = 2'b10;
        case (op_i)
          2'b01:   state_d = StMemAdr;
          2'b00:   state_d = funct_i[5] ? StExecuteI : StExecuteR;
          2'b10:   state_d = StBranch;
          default: state_d = StUnknown;
        endcase
      end
      StMemAdr: begin
        alu_src_b_o = 2'b01;
        state_d     = funct_i[0] ? StMemRd : StMemWr;
      end
      StMemRd: begin
        adr_src_o = 1'b1;
        state_d   = StMemWb;
      end
      StMemWb: begin
        result_src_o = 2'b01;
        reg_w        = 1'b1;
        state_d      = StFetch;
      end
      StMemWr: begin
        adr_src_o = 1'b1;
        mem_w     = 1'b1;
        state_d   = StFetch;
      end
      StExecuteR: begin
        alu_op  = 1'b1;
        state_d = StAluWb;
      end
      StExecuteI: begin
        alu_src_b_o = 2'b01;
        alu_op      = 1'b1;
        state_d     = StAluWb;
      end
      StAluWb: begin
        reg_w   = 1'b1;
        state_d = StFetch;
      end
      StBranch: begin
        alu_src_b_o  = 2'b01;
        result_src_o = 2'b10;
        branch       = 1'b1;
        state_d      = StFetch;
      end
      default: state_d = StFetch;
    endcase
  end

  assign is_add = (funct_i[4:1] == 4'b0100);
  assign is_sub = (funct_i[4:1] == 4'b0010);

  always_comb begin
    alu_control_o = 2'b00;
    flag_w        = 2'b00;
    if (alu_op) begin
      case (funct_i[4:1])
        4'b0100: alu_control_o = 2'b00;
        4'b0010: alu_control_o = 2'b01;
        4'b0000: alu_control_o = 2'b10;
        4'b1100: alu_control_o = 2'b11;
        default: alu_control_o = 2'b00;
      endcase
      flag_w[1] = funct_i[0];
      flag_w[0] = funct_i[0] & (is_add | is_sub);
    end
  end

  assign {n, z, c, v} = flags_q;

  always_comb begin
    case (cond_i)
      4'b0000: cond_ex = z;
      4'b0001: cond_ex = ~z;
      4'b0010: cond_ex = c;
      4'b0011: cond_ex = ~c;
      4'b0100: cond_ex = n;
      4'b0101: cond_ex = ~n;
      4'b0110: cond_ex = v;
      4'b0111: cond_ex = ~v;
      4'b1000: cond_ex = c & ~z;
      4'b1001: cond_ex = ~c | z;
      4'b1010: cond_ex = (n == v);
      4'b1011: cond_ex = (n != v);
      4'b1100: cond_ex = ~z & (n == v);
      4'b1101: cond_ex = z | (n != v);
      4'b1110: cond_ex = 1'b1;
      default: cond_ex = 1'b0;
    endcase
  end

  always_comb begin
    flags_d = flags_q;
    if (flag_w[1] & cond_ex) flags_d[3:2] = alu_flags_i[3:2];
    if (flag_w[0] & cond_ex) flags_d[1:0] = alu_flags_i[1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StFetch;
      flags_q     <= 4'b0000;
      cond_ex_r_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      flags_q     <= flags_d;
      cond_ex_r_q <= cond_ex;
    end
  end

  // Strobes are gated by reset so the FETCH state held during reset stays inert.
  assign pcs         = ((rd_i == 4'b1111) & reg_w) | branch;
  assign pc_write_o  = rst_ni & ((pcs & cond_ex_r_q) | next_pc);
  assign ir_write_o  = rst_ni & ir_w;
  assign reg_write_o = rst_ni & reg_w & cond_ex_r_q;
  assign mem_write_o = rst_ni & mem_w & cond_ex_r_q;

  assign reg_src_o = {(op_i == 2'b01), (op_i == 2'b10)};
  assign imm_src_o = op_i;

endmodule

// File: tb/tb_mc_controller.sv
// Bench for mc_controller: directed instruction table, hand-written corner
// sequences (reset mid-instruction) and random instructions against a model.
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond, rd, alu_flags;
  logic [1:0] op;
  logic [5:0] funct;
  logic       pc_write, ir_write, reg_write, mem_write, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, reg_src, imm_src, alu_control;

  always #5 clk = ~clk;

  mc_controller dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cond_i       (cond),
    .op_i         (op),
    .funct_i      (funct),
    .rd_i         (rd),
    .alu_flags_i  (alu_flags),
    .pc_write_o   (pc_write),
    .ir_write_o   (ir_write),
    .reg_write_o  (reg_write),
    .mem_write_o  (mem_write),
    .adr_src_o    (adr_src),
    .alu_src_a_o  (alu_src_a),
    .alu_src_b_o  (alu_src_b),
    .result_src_o (result_src),
    .reg_src_o    (reg_src),
    .imm_src_o    (imm_src),
    .alu_control_o(alu_control)
  );

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Per-cycle capture of one instruction, cycle 0 = FETCH.
  logic       c_ir[10], c_pc[10], c_rw[10], c_mw[10], c_adr[10], c_srca[10];
  logic [1:0] c_srcb[10], c_res[10], c_actl[10], c_rsrc[10], c_isrc[10];
  int         lat;

  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] r, input logic [3:0] a);
    cond = c; op = o; funct = f; rd = r; alu_flags = a;
    lat = -1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k > 0 && ir_write) begin
        lat = k;
        break;
      end
      c_ir[k] = ir_write;   c_pc[k] = pc_write;  c_rw[k] = reg_write;
      c_mw[k] = mem_write;  c_adr[k] = adr_src;  c_srca[k] = alu_src_a;
      c_srcb[k] = alu_src_b; c_res[k] = result_src; c_actl[k] = alu_control;
      c_rsrc[k] = reg_src;  c_isrc[k] = imm_src;
      @(negedge clk);
    end
  endtask

  function automatic int cnt_rw();
    int s = 0;
    for (int k = 0; k < ((lat < 0) ? 10 : lat); k++) s += int'(c_rw[k]);
    return s;
  endfunction
  function automatic int cnt_mw();
    int s = 0;
    for (int k = 0; k < ((lat < 0) ? 10 : lat); k++) s += int'(c_mw[k]);
    return s;
  endfunction
  function automatic int cnt_pc();
    int s = 0;
    for (int k = 0; k < ((lat < 0) ? 10 : lat); k++) s += int'(c_pc[k]);
    return s;
  endfunction

  // Reference: ARM condition codes over {N,Z,C,V}.
  function automatic bit holds(input logic [3:0] c, input logic [3:0] fl);
    bit n = fl[3], z = fl[2], cf = fl[1], v = fl[0];
    case (c)
      0: return z;            1: return !z;
      2: return cf;           3: return !cf;
      4: return n;            5: return !n;
      6: return v;            7: return !v;
      8: return cf && !z;     9: return !cf || z;
      10: return n == v;      11: return n != v;
      12: return !z && (n == v);
      13: return z || (n != v);
      14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  typedef struct {
    logic [3:0] c; logic [1:0] o; logic [5:0] f; logic [3:0] r; logic [3:0] a;
    int lat; int rw; int mw; int pcw; int actl;
  } vec_t;

  vec_t tbl[17];
  logic [3:0] mflags;
  logic [3:0] cmds[4];

  initial begin
    // cond op funct rd aluflags | lat rw mw pcw aluctl(-1 = n/a)
    tbl[0]  = '{4'he, 2'b00, 6'b001000, 4'h1, 4'h0, 4, 1, 0, 1, 0};  // ADD
    tbl[1]  = '{4'he, 2'b00, 6'b000101, 4'h2, 4'h6, 4, 1, 0, 1, 1};  // SUBS -> 0110
    tbl[2]  = '{4'h0, 2'b10, 6'b000000, 4'h0, 4'h0, 3, 0, 0, 2, -1}; // BEQ taken
    tbl[3]  = '{4'h1, 2'b10, 6'b000000, 4'h0, 4'h0, 3, 0, 0, 1, -1}; // BNE not taken
    tbl[4]  = '{4'he, 2'b01, 6'b011001, 4'h3, 4'h0, 5, 1, 0, 1, -1}; // LDR
    tbl[5]  = '{4'he, 2'b01, 6'b011000, 4'h3, 4'h0, 4, 0, 1, 1, -1}; // STR
    tbl[6]  = '{4'he, 2'b00, 6'b001001, 4'h4, 4'h8, 4, 1, 0, 1, 0};  // ADDS -> 1000
    tbl[7]  = '{4'h0, 2'b00, 6'b001001, 4'h4, 4'h4, 4, 0, 0, 1, 0};  // ADDSEQ, Z=0
    tbl[8]  = '{4'h4, 2'b10, 6'b000000, 4'h0, 4'h0, 3, 0, 0, 2, -1}; // BMI, N kept
    tbl[9]  = '{4'he, 2'b00, 6'b001000, 4'hf, 4'h0, 4, 1, 0, 2, 0};  // ADD to PC
    tbl[10] = '{4'he, 2'b11, 6'b000000, 4'h0, 4'h0, 3, 0, 0, 1, -1}; // unknown
    tbl[11] = '{4'he, 2'b00, 6'b111000, 4'h5, 4'h0, 4, 1, 0, 1, 3};  // ORR imm
    tbl[12] = '{4'he, 2'b00, 6'b000000, 4'h5, 4'h0, 4, 1, 0, 1, 2};  // AND
    tbl[13] = '{4'he, 2'b00, 6'b000010, 4'h5, 4'h0, 4, 1, 0, 1, 0};  // EOR -> 00
    tbl[14] = '{4'hf, 2'b00, 6'b001000, 4'h1, 4'h0, 4, 0, 0, 1, 0};  // cond 1111
    tbl[15] = '{4'he, 2'b01, 6'b000001, 4'hf, 4'h0, 5, 1, 0, 2, -1}; // LDR to PC
    tbl[16] = '{4'h0, 2'b01, 6'b000000, 4'h3, 4'h0, 4, 0, 0, 1, -1}; // STREQ fails
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000; cmds[3] = 4'b1100;

    rst_n = 1'b0; cond = 0; op = 0; funct = 0; rd = 0; alu_flags = 0;
    #1;
    chk("reset_strobes", int'({pc_write, ir_write, reg_write, mem_write}), 0);
    @(posedge clk); #1;
    chk("reset_strobes_edge", int'({pc_write, ir_write, reg_write, mem_write}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("fetch_after_reset", int'(ir_write), 1);

    foreach (tbl[i]) begin
      run_instr(tbl[i].c, tbl[i].o, tbl[i].f, tbl[i].r, tbl[i].a);
      chk($sformatf("t%0d_lat", i), lat, tbl[i].lat);
      chk($sformatf("t%0d_rw", i), cnt_rw(), tbl[i].rw);
      chk($sformatf("t%0d_mw", i), cnt_mw(), tbl[i].mw);
      chk($sformatf("t%0d_pcw", i), cnt_pc(), tbl[i].pcw);
      chk($sformatf("t%0d_fetch", i),
          int'({c_ir[0], c_pc[0], c_adr[0], c_srca[0], c_srcb[0], c_res[0]}), 8'b1101_1010);
      chk($sformatf("t%0d_srcs", i), int'({c_rsrc[1], c_isrc[1]}),
          int'({tbl[i].o == 2'b01, tbl[i].o == 2'b10, tbl[i].o}));
      if (tbl[i].actl >= 0) chk($sformatf("t%0d_actl", i), int'(c_actl[2]), tbl[i].actl);
    end

    // Cycle-level corner sequences.
    run_instr(4'he, 2'b00, 6'b001000, 4'h1, 4'h0);
    chk("add_rw_pattern", int'({c_rw[3], c_rw[2], c_rw[1], c_rw[0]}), 4'b1000);
    chk("add_exec_srcb", int'({c_srca[2], c_srcb[2]}), 3'b000);
    chk("add_wb_res", int'(c_res[3]), 0);
    run_instr(4'he, 2'b01, 6'b011001, 4'h3, 4'h0);
    chk("ldr_memadr", int'({c_adr[2], c_srca[2], c_srcb[2]}), 3'b001);
    chk("ldr_memrd_adr", int'(c_adr[3]), 1);
    chk("ldr_memwb", int'({c_res[4], c_rw[4]}), 3'b011);
    run_instr(4'he, 2'b01, 6'b011000, 4'h3, 4'h0);
    chk("str_memwr", int'({c_adr[3], c_mw[3]}), 2'b11);
    run_instr(4'he, 2'b10, 6'b000000, 4'h0, 4'h0);
    chk("b_branch_sel", int'({c_srca[2], c_srcb[2], c_res[2]}), 5'b00110);

    // Reset asserted in EXECUTEI after flags were set to 0110.
    run_instr(4'he, 2'b00, 6'b000101, 4'h2, 4'h6);
    cond = 4'he; op = 2'b00; funct = 6'b101001; rd = 4'h1; alu_flags = 4'hf;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("rst_mid_strobes%0d", k),
          int'({pc_write, ir_write, reg_write, mem_write}), 0);
      @(negedge clk);
    end
    rst_n = 1'b1;
    #1;
    chk("rst_mid_fetch", int'(ir_write), 1);
    run_instr(4'h0, 2'b10, 6'b000000, 4'h0, 4'h0);
    chk("rst_flags_z", cnt_pc(), 1);
    run_instr(4'h5, 2'b10, 6'b000000, 4'h0, 4'h0);
    chk("rst_flags_n", cnt_pc(), 2);
    run_instr(4'h3, 2'b10, 6'b000000, 4'h0, 4'h0);
    chk("rst_flags_c", cnt_pc(), 2);

    // Random instructions against the instruction-level model.
    mflags = 4'h0;
    for (int i = 0; i < 200; i++) begin
      logic [3:0] c, r, a;
      logic [1:0] o;
      logic [5:0] f;
      logic [3:0] cmd;
      bit ok;
      int e_rw, e_mw, e_pcw, e_lat;
      c = 4'($urandom_range(0, 15));
      o = 2'($urandom_range(0, 3));
      f = 6'($urandom);
      r = ($urandom_range(0, 3) == 0) ? 4'hf : 4'($urandom_range(0, 15));
      a = 4'($urandom);
      cmd = cmds[$urandom_range(0, 3)];
      if (o == 2'b00) f[4:1] = cmd;
      ok = holds(c, mflags);
      e_lat = (o == 2'b00) ? 4 : (o == 2'b01) ? (f[0] ? 5 : 4) : 3;
      e_rw  = ((o == 2'b00 || (o == 2'b01 && f[0])) && ok) ? 1 : 0;
      e_mw  = (o == 2'b01 && !f[0] && ok) ? 1 : 0;
      e_pcw = 1 + (((o == 2'b10 && ok) || (e_rw == 1 && r == 4'hf)) ? 1 : 0);
      run_instr(c, o, f, r, a);
      chk($sformatf("r%0d_lat", i), lat, e_lat);
      chk($sformatf("r%0d_rw", i), cnt_rw(), e_rw);
      chk($sformatf("r%0d_mw", i), cnt_mw(), e_mw);
      chk($sformatf("r%0d_pcw", i), cnt_pc(), e_pcw);
      if (o == 2'b00) begin
        chk($sformatf("r%0d_actl", i), int'(c_actl[2]),
            (cmd == 4'b0100) ? 0 : (cmd == 4'b0010) ? 1 : (cmd == 4'b0000) ? 2 : 3);
        chk($sformatf("r%0d_srcb", i), int'(c_srcb[2]), f[5] ? 1 : 0);
        if (f[0] && ok) begin
          mflags[3:2] = a[3:2];
          if (cmd == 4'b0100 || cmd == 4'b0010) mflags[1:0] = a[1:0];
        end
      end
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 Parameters: none; all encodings below SHALL be fixed.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset  input  1  asynchronous, active-low; 0 = in reset.
REQ-004 Cond  input  4  Instr[31:28].
REQ-005 Op  input  2  Instr[27:26].
REQ-006 Funct  input  6  Instr[25:20].
REQ-007 Rd  input  4  Instr[15:12].
REQ-008 ALUFlags  input  4  {N,Z,C,V} from ALU, current cycle.
REQ-009 PCWrite, IRWrite, RegWrite, MemWrite  output  1 each  datapath write strobes.
REQ-010 AdrSrc  output  1  memory address select: 0 = PC, 1 = ALUOut.
REQ-011 ALUSrcA  output  1  ALU A input select: 0 = A reg, 1 = PC.
REQ-012 ALUSrcB  output  2  ALU B input select: 00 = WriteData, 01 = ExtImm, 10 = constant 4.
REQ-013 ResultSrc  output  2  result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
REQ-014 RegSrc, ImmSrc, ALUControl  output  2 each  register-read selects, extend mode, ALU op (00 ADD, 01 SUB, 10 AND, 11 ORR).

Function
REQ-015 Moore FSM states SHALL be FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN.
REQ-016 FETCH SHALL drive AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, NextPC=1, then go to DECODE.
REQ-017 DECODE SHALL drive ALUSrcA=1, ALUSrcB=10, ResultSrc=10, then branch on Op/Funct[5]: 01 -> MEMADR; 00,F5=0 -> EXECUTER; 00,F5=1 -> EXECUTEI; 10 -> BRANCH; 11 -> UNKNOWN.
REQ-018 MEMADR SHALL drive ALUSrcA=0, ALUSrcB=01, then go to MEMRD if Funct[0]=1, else MEMWR.
REQ-019 MEMRD: AdrSrc=1 -> MEMWB. MEMWB: ResultSrc=01, RegW=1 -> FETCH. MEMWR: AdrSrc=1, MemW=1 -> FETCH.
REQ-020 EXECUTER (ALUSrcB=00) and EXECUTEI (ALUSrcB=01) SHALL drive ALUSrcA=0, ALUOp=1, then go to ALUWB; ALUWB SHALL drive ResultSrc=00, RegW=1, then go to FETCH.
REQ-021 BRANCH SHALL drive ALUSrcA=0, ALUSrcB=01, ResultSrc=10, Branch=1, then go to FETCH; UNKNOWN SHALL assert nothing and go to FETCH.
REQ-022 Unlisted outputs SHALL be 0 in every state; ALUOp=0 SHALL force ALUControl=00 and FlagW=00.
REQ-023 ALUOp=1 decode on Funct[4:1]: 0100 -> 00, 0010 -> 01, 0000 -> 10, 1100 -> 11, other -> 00; FlagW[1]=Funct[0]; FlagW[0]=Funct[0] and (ADD or SUB).
REQ-024 RegSrc[0] SHALL equal (Op==10), RegSrc[1] SHALL equal (Op==01), and ImmSrc SHALL equal Op, all combinationally from Op in every state.
REQ-025 CondEx combinational from Cond and Flags: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 -> 0.
REQ-026 Flags[3:2] SHALL load ALUFlags[3:2] at the clock edge when FlagW[1]&CondEx; Flags[1:0] SHALL load ALUFlags[1:0] when FlagW[0]&CondEx.
REQ-027 CondExR SHALL register CondEx every cycle, so write-back states use the condition evaluated with pre-execute flags.
REQ-028 PCS=(Rd==1111 & RegW) | Branch; PCWrite=(PCS & CondExR) | NextPC; RegWrite=RegW & CondExR; MemWrite=MemW & CondExR.
REQ-029 Latency SHALL be: data-processing 4 cycles, LDR 5, STR 4, branch 3, unknown 3.

Reset
REQ-030 reset=0 SHALL immediately set state=FETCH, Flags=0000, CondExR=0, from any state including mid-instruction.
REQ-031 While reset=0, PCWrite, IRWrite, RegWrite and MemWrite SHALL be forced to 0; FETCH behaviour SHALL begin on the first rising edge after reset returns to 1.

Verification
REQ-032 ADD (Cond=1110, Op=00, Funct=001000, Rd=0001) -> FETCH, DECODE, EXECUTER, ALUWB; ALUControl=00 in EXECUTER; RegWrite=1 in ALUWB only.
REQ-033 SUBS (Funct=000101) with ALUFlags=0110 -> Flags=0110; next BEQ (Cond=0000, Op=10) -> PCWrite=1 in BRANCH; BNE -> PCWrite=0 in BRANCH.
REQ-034 LDR (Op=01, Funct=011001) -> 5 states, AdrSrc=1 in MEMRD, ResultSrc=01 and RegWrite=1 in MEMWB; STR (Funct[0]=0) -> MemWrite=1 in MEMWR, 4 cycles.
REQ-035 ADDSEQ with Z=0 -> ALUWB reached, RegWrite=0, Flags unchanged; ADD with Rd=1111 -> RegWrite=1 and PCWrite=1 in ALUWB.
REQ-036 Op=11 -> DECODE, UNKNOWN, FETCH with no strobes; reset=0 asserted in EXECUTEI -> FETCH, Flags=0000, all strobes 0 while reset is low.
